// File: rtl/if_id_queue_if.sv
// Handshake bundle between the IF stage, the IF/ID queue and the ID stage.
// The master modport is the driver side (fetch + decode control); slave is the queue.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    logic                     if_valid;
    logic [ADDR_W-1:0]        if_pc;
    logic [INST_W-1:0]        if_inst;
    logic                     if_ready;
    logic                     flush;
    logic                     id_stall;
    logic                     id_valid;
    logic [ADDR_W-1:0]        id_pc;
    logic [INST_W-1:0]        id_inst;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output if_valid, if_pc, if_inst, flush, id_stall,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, id_stall,
        output if_ready, id_valid, id_pc, id_inst, count
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of (pc, inst) pairs between IF and ID, with whole-queue flush.
// All outputs decode registered state only; an empty queue presents an all-zero bubble.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    if_id_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_valid;
    logic w_ready;
    logic w_push;
    logic w_pop;

    assign w_valid = (r_cnt != '0);
    assign w_ready = (r_cnt != CNT_FULL);
    assign w_push  = bus.if_valid & w_ready;
    assign w_pop   = w_valid & ~bus.id_stall;

    assign bus.id_valid = w_valid;
    assign bus.if_ready = w_ready;
    assign bus.count    = r_cnt;
    assign bus.id_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign bus.id_inst  = w_valid ? r_inst_mem[r_rd_ptr] : '0;

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // alone decide which slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= bus.if_pc;
            r_inst_mem[r_wr_ptr] <= bus.if_inst;
        end
    end

    // NOTE: non-blocking assignments keep every register update reading the
    // pre-edge values, so cnt and both pointers move consistently in one cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a driver commits accepted pushes into an
// expected-entry queue; a negedge monitor compares the DUT against it every cycle.
module tb_if_id_queue;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    if_id_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

    if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    entry_t exp_q[$];
    bit     mon_en  = 1'b0;

    // Decision of the cycle currently being driven, committed after its edge.
    bit     pend_clear = 1'b1;
    bit     pend_push  = 1'b0;
    entry_t pend_entry;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: expected outputs follow from the entry queue alone.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit     has  = (exp_q.size() != 0);
            automatic entry_t head = '{pc: '0, inst: '0};
            if (has) head = exp_q[0];
            check("id_valid", 64'(bus.id_valid), 64'(has));
            check("if_ready", 64'(bus.if_ready), 64'(exp_q.size() != DEPTH));
            check("count",    64'(bus.count),    64'(exp_q.size()));
            check("id_pc",    64'(bus.id_pc),    64'(head.pc));
            check("id_inst",  64'(bus.id_inst),  64'(head.inst));
            if (has && !bus.id_stall && !bus.flush && !rst) void'(exp_q.pop_front());
        end
    end

    task automatic commit();
        if (pend_clear) exp_q.delete();
        else if (pend_push) exp_q.push_back(pend_entry);
    endtask

    // Drive one cycle of inputs; returns just after the following posedge.
    task automatic step(input logic v, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                        input logic stall, input logic fl, input logic r);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.id_stall = stall;
        bus.flush    = fl;
        rst          = r;
        pend_clear   = r | fl;
        pend_push    = v && (exp_q.size() < DEPTH);
        pend_entry   = '{pc: pc, inst: inst};
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic idle(input int n, input logic stall);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, stall, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_inst  = '0;
        bus.id_stall = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        commit();
        mon_en = 1'b1;

        // Reset held, then idle.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Single flow with no stall.
        step(1'b1, 32'h0000_0004, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Fill under stall, fifth push dropped, then drain in order.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(5, 1'b0);

        // Reach count 2, then 10 simultaneous push+pop to wrap the pointers.
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Flush at count 3 with stall and a same-cycle push.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h2FC, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Reset together with flush at count 2, then a push right after.
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'h300 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h3FC, 32'hFEED_F00D, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h400, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 99) < 65),
                 32'($urandom), 32'($urandom),
                 logic'($urandom_range(0, 99) < 45),
                 logic'($urandom_range(0, 99) < 4),
                 logic'($urandom_range(0, 99) < 2));
        end
        idle(DEPTH + 2, 1'b0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID pipeline buffer; replaces the single-entry IF/ID latch with a DEPTH-entry FIFO of (pc, inst) pairs.
- Decouples fetch from decode: IF keeps fetching while ID stalls, up to DEPTH instructions.
- Supports a whole-queue flush on branch mispredict or exception (flush).
- Presents a zero bubble to ID when the queue is empty.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- if_valid  in  1  IF presents a valid instruction this cycle.
- if_pc  in  ADDR_W  PC of the IF instruction.
- if_inst  in  INST_W  IF instruction word.
- if_ready  out  1  queue can accept a push this cycle.
- flush  in  1  discard all queued entries (mispredict or exception).
- id_stall  in  1  ID cannot consume this cycle.
- id_valid  out  1  head entry is valid.
- id_pc  out  ADDR_W  head PC; 0 when id_valid=0.
- id_inst  out  INST_W  head instruction; 0 (bubble) when id_valid=0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- State:
  - storage arrays pc_mem[DEPTH] and inst_mem[DEPTH];
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - cnt register.
- Outputs are combinational from registered state only:
  - id_valid = (cnt != 0);
  - if_ready = (cnt != DEPTH);
  - count = cnt.
  - No combinational path from any input to any output.
- id_pc/id_inst = pc_mem[rd_ptr]/inst_mem[rd_ptr] when id_valid, else all-zero.
- push = if_valid & if_ready. pop = id_valid & ~id_stall.
- Priority per posedge: rst > flush > push/pop.
- Reset:
  - wr_ptr=rd_ptr=cnt=0;
  - id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
  - Storage contents need not be cleared.
  - Reset during a stall or mid-fill discards everything; the next cycle is empty.
- Flush (rst=0):
  - wr_ptr=rd_ptr=cnt=0;
  - any same-cycle push is dropped and any same-cycle pop is void.
  - Flush wins over id_stall.
  - The cycle after a flush: id_valid=0, outputs zero.
- Push: write if_pc/if_inst at wr_ptr; wr_ptr+1 (wraps DEPTH-1→0).
- Pop: rd_ptr+1 (wraps).
- Count update:
  - push only: cnt+1;
  - pop only: cnt-1;
  - both: cnt unchanged, both pointers advance.
- Full (cnt=DEPTH):
  - if_ready=0, so a push is refused even if a pop occurs the same cycle (no same-cycle bypass).
  - IF must hold its instruction.
- Empty (cnt=0):
  - pop cannot occur;
  - a push makes the entry visible at id_* the next cycle (1-cycle IF→ID latency, matching the old latch);
  - no write-through.
- if_valid=0 or if_ready=0: no state change from the IF side. if_pc/if_inst are don't-care.
- id_stall=1: head entry is held stable on id_* until popped or flushed.
- cnt never exceeds DEPTH and never underflows. Pointers are equal when empty and equal when full; cnt disambiguates.

Test Plan:
- Reset, then idle → id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
- Single flow, id_stall=0:
  - push pc=0x00000004 inst=0x00100093 at cycle N;
  - → at N+1 id_valid=1, id_pc=4, id_inst=0x00100093;
  - popped at N+1, empty at N+2.
- Fill with id_stall=1:
  - push pc 0x10,0x14,0x18,0x1C → count=4, if_ready=0, id_pc=0x10 held;
  - a fifth push with if_valid=1 is dropped.
  - Release the stall → entries appear in order 0x10,0x14,0x18,0x1C on consecutive cycles.
- Simultaneous push+pop at count=2 → count stays 2, FIFO order preserved. Run 10 continuous pushes/pops to exercise pointer wrap past DEPTH-1.
- Flush with count=3, id_stall=1, if_valid=1 → next cycle count=0, id_valid=0, id_inst=0; the flushed-cycle push is not present.
- rst asserted with count=2 and flush=1 → count=0, if_ready=1. The first push after rst deasserts appears at id_* one cycle later.
